canny_stage_scheduler: RTL and testbench
========================================

Name: canny_stage_scheduler

Overview:
- Sequences the four-stage edge pipeline: Gaussian 9x9 window, gradient 7x7, suppression 5x5, hysteresis 3x3.
- Generates a serpentine raster scan, one step per cycle while SRAM read data is ready.
- Issues a per-stage shift enable and shift direction, with each stage one cycle behind the previous, and counts fill per stage.
- Drives write_enable and write_address to the write SRAM only for fully primed pixels. Sits between the read-memory side and the buffer chain, and replaces ad-hoc fill/enable sequencing.

Parameters:
- IMG_W, 512, pixels per row (steps per row).
- IMG_H, 512, rows per frame.
- FILL_GAUSS, 9, shifts needed to prime stage 0.
- FILL_GRAD, 7, shifts needed to prime stage 1.
- FILL_SUPP, 5, shifts needed to prime stage 2.
- FILL_HYST, 3, shifts needed to prime stage 3.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  begin frame (level, sampled in IDLE)
- mem_ready  in  1  SRAM read data for the current step is valid
- gauss_en / grad_en / supp_en / hyst_en  out  1 each  stage shift enables
- gauss_dir / grad_dir / supp_dir / hyst_dir  out  2 each  stage shift directions
- write_enable  out  1  write SRAM strobe
- write_address  out  18  write SRAM address
- scan_x  out  9  current step column
- scan_y  out  9  current step row
- busy  out  1  high in SCAN or DRAIN
- frame_done  out  1  one-cycle pulse at end of frame
- error  out  1  one-cycle pulse on illegal start
- stall_cycles  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset: clk is the only clock; n_rst is synchronous and active-low. Reset applies on any edge, mid-frame included. Afterwards all enables, write_enable, busy, frame_done and error are 0. All dirs are DIR_HOLD. Addresses, scan coordinates, counters and fill counters are 0. State is IDLE.
- Direction encoding: DIR_RIGHT=00, DIR_LEFT=01, DIR_DOWN=10, DIR_HOLD=11. Any dir whose enable is 0 reads DIR_HOLD.
- FSM:
  - IDLE -> SCAN on start; clears fill counters and write_address.
  - SCAN issues a step on every cycle with mem_ready=1.
  - SCAN -> DRAIN after step IMG_W*IMG_H-1 is issued.
  - DRAIN -> DONE when the stage pipeline holds no valid entry.
  - DONE pulses frame_done, then returns to IDLE.
- Step direction:
  - Step 0 is DIR_RIGHT.
  - The first step of row r>0 is DIR_DOWN.
  - Other steps are DIR_RIGHT in even rows and DIR_LEFT in odd rows.
  - scan_x walks serpentine; scan_y increments on DIR_DOWN.
- Staging:
  - The step issued at cycle t appears on stage 0 at t, stage 1 at t+1, stage 2 at t+2, stage 3 at t+3.
  - Each pipeline entry carries {valid, dir, good}.
  - A cycle with mem_ready=0 inserts a bubble (valid=0) that propagates. Stages never stall each other.
- Fill:
  - Stage k counts valid shifts whose incoming good flag is set; stage 0's incoming flag is always 1. The counter saturates at FILL_k.
  - The outgoing good flag is 1 when that shift makes or keeps the counter at FILL_k.
  - With defaults, the first good stage-3 entry is step index 20 (0-based).
- Write:
  - write_enable=1 at t+4 for each good stage-3 entry.
  - write_address holds the current address during the pulse and then increments.
  - Writes per frame = IMG_W*IMG_H - (sum of FILL_* - 4).
- Illegal start: start while busy pulses error for one cycle and is otherwise ignored.

Optional Feature:
- Macro: CANNY_STALL_COUNT_EN.
- Defined: stall_cycles counts cycles in SCAN with mem_ready=0. It saturates at 16'hFFFF and clears on frame start.
- Not defined: stall_cycles is constant 0 and no counter logic exists.

Decomposition:
- Package canny_sched_pkg holds:
  - the dir_t enum (RIGHT/LEFT/DOWN/HOLD);
  - the state_t enum (IDLE/SCAN/DRAIN/DONE);
  - the stage_entry_t struct {valid, dir, good};
  - default FILL_* constants.
- Sub-module stage_fill_tracker has parameter FILL and holds one saturating counter plus good-flag logic. It is instantiated four times.

Test Plan:
- Reset: hold n_rst=0 for 3 cycles, then release -> all enables 0, all dirs 11, write_address=0, busy=0.
- Full frame, IMG_W=8, IMG_H=4, mem_ready=1:
  - gauss_dir sequence: 8xR; D,7xL; D,7xR; D,7xL (32 steps).
  - 12 write_enable pulses with addresses 0..11; the first is 4 cycles after step 20.
  - frame_done fires once; busy drops.
- Same frame with mem_ready alternating 1/0 -> still 32 stage-0 shifts and 12 writes. Each stage's enable is exactly 1 cycle after the previous stage's.
- start pulsed at step 10 of a frame -> error high for 1 cycle; dir sequence and write count unchanged.
- n_rst low at step 10 -> idle outputs on the next cycle. A new start -> 12 writes, addresses 0..11.
- With CANNY_STALL_COUNT_EN, mem_ready low for 5 SCAN cycles -> stall_cycles=5. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/canny_stage_scheduler_pkg.sv
// canny_sched_pkg: shared types and constants for the Canny stage scheduler.
//   dir_t          shift direction carried down the stage chain
//   state_t        scheduler FSM state (values pinned to legacy ST_* codes)
//   stage_entry_t  one pipeline slot {valid, dir, good}
//   FILL_*_DEFAULT window depths of the four buffer stages
package canny_sched_pkg;

    localparam int unsigned FILL_GAUSS_DEFAULT = 9;
    localparam int unsigned FILL_GRAD_DEFAULT  = 7;
    localparam int unsigned FILL_SUPP_DEFAULT  = 5;
    localparam int unsigned FILL_HYST_DEFAULT  = 3;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SCAN  = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_HOLD  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SCAN  = ST_SCAN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
        logic good;
    } stage_entry_t;

    localparam stage_entry_t EMPTY_ENTRY = '{valid: 1'b0, dir: DIR_HOLD, good: 1'b0};

    // A stage that is not shifting always presents HOLD on its dir output.
    function automatic dir_t shown_dir(input stage_entry_t e);
        return e.valid ? e.dir : DIR_HOLD;
    endfunction

endpackage

// File: rtl/canny_stage_scheduler_if.sv
// canny_stage_scheduler_if: control bundle between the read side, the
// scheduler and the four-stage buffer chain.
//   master modport: the scheduler (samples start/mem_ready, drives the rest)
//   slave modport : the surrounding system / read-memory side
// Signals:
//   start, mem_ready                      frame request, read data valid
//   {gauss,grad,supp,hyst}_en / _dir      per-stage shift enable / direction
//   write_enable, write_address[17:0]     write SRAM strobe and address
//   scan_x[8:0], scan_y[8:0]              current step coordinates
//   busy, frame_done, error               status
//   stall_cycles[15:0]                    read-stall counter (optional)
interface canny_stage_scheduler_if;

    logic        start;
    logic        mem_ready;
    logic        gauss_en;
    logic        grad_en;
    logic        supp_en;
    logic        hyst_en;
    logic [1:0]  gauss_dir;
    logic [1:0]  grad_dir;
    logic [1:0]  supp_dir;
    logic [1:0]  hyst_dir;
    logic        write_enable;
    logic [17:0] write_address;
    logic [8:0]  scan_x;
    logic [8:0]  scan_y;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic [15:0] stall_cycles;

    modport master (
        input  start, mem_ready,
        output gauss_en, grad_en, supp_en, hyst_en,
        output gauss_dir, grad_dir, supp_dir, hyst_dir,
        output write_enable, write_address, scan_x, scan_y,
        output busy, frame_done, error, stall_cycles
    );

    modport slave (
        output start, mem_ready,
        input  gauss_en, grad_en, supp_en, hyst_en,
        input  gauss_dir, grad_dir, supp_dir, hyst_dir,
        input  write_enable, write_address, scan_x, scan_y,
        input  busy, frame_done, error, stall_cycles
    );

endinterface

// File: rtl/canny_stage_scheduler_stage_fill_tracker.sv
// stage_fill_tracker: priming tracker for one buffer stage.
// Counts valid shifts whose incoming good flag is set, saturating at FILL,
// and flags a shift as good once it makes or keeps the count at FILL.
//   clk, n_rst  clock, synchronous active-low reset
//   clear       restart priming (frame start)
//   shift       a valid entry is shifting into this stage
//   good_in     incoming good flag of that entry
//   good_out    outgoing good flag of that entry
module stage_fill_tracker #(
    parameter int unsigned FILL = 9
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic shift,
    input  logic good_in,
    output logic good_out
);

    localparam int unsigned CW = $clog2(FILL + 1);
    localparam logic [CW-1:0] FILL_MAX  = CW'(FILL);
    localparam logic [CW-1:0] FILL_LAST = CW'(FILL - 1);

    logic [CW-1:0] fill_count;
    logic          counted;

    assign counted = shift && good_in;

    // The count is still pre-increment here, so FILL-1 means this shift
    // completes the window.
    assign good_out = counted && (fill_count >= FILL_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            fill_count <= '0;
        end else if (counted && (fill_count != FILL_MAX)) begin
            fill_count <= fill_count + 1'b1;
        end
    end

endmodule

// File: rtl/canny_stage_scheduler.sv
// canny_stage_scheduler: sequences the Gaussian 9x9 / gradient 7x7 /
// suppression 5x5 / hysteresis 3x3 buffer chain over a serpentine raster.
// One step per cycle while mem_ready is high; each stage sees the step one
// cycle after the previous one; writes are issued only for pixels that are
// fully primed through all four stages.
// Ports:
//   clk    system clock
//   n_rst  synchronous active-low reset
//   bus    canny_stage_scheduler_if.master (handshake, enables, write side)
// Build option: CANNY_STALL_COUNT_EN adds the stall_cycles counter;
// without it stall_cycles is tied to zero.
module canny_stage_scheduler
    import canny_sched_pkg::*;
#(
    parameter int unsigned IMG_W      = 512,
    parameter int unsigned IMG_H      = 512,
    parameter int unsigned FILL_GAUSS = FILL_GAUSS_DEFAULT,
    parameter int unsigned FILL_GRAD  = FILL_GRAD_DEFAULT,
    parameter int unsigned FILL_SUPP  = FILL_SUPP_DEFAULT,
    parameter int unsigned FILL_HYST  = FILL_HYST_DEFAULT
) (
    input  logic                     clk,
    input  logic                     n_rst,
    canny_stage_scheduler_if.master  bus
);

    localparam logic [8:0] LAST_COL = 9'(IMG_W - 1);
    localparam logic [8:0] LAST_ROW = 9'(IMG_H - 1);

    state_t       state;
    logic [8:0]   col;
    logic [8:0]   scan_x;
    logic [8:0]   scan_y;
    dir_t         step_dir;
    logic         frame_start;
    logic         step;
    logic         last_step;
    logic         pipe_empty;
    logic         busy;
    logic         error;
    logic         write_enable;
    logic [17:0]  write_address;
    stage_entry_t s0;
    stage_entry_t s1;
    stage_entry_t s2;
    stage_entry_t s3;
    logic         good0;
    logic         good1;
    logic         good2;
    logic         good3;

    assign frame_start = (state == IDLE) && bus.start;
    assign step        = (state == SCAN) && bus.mem_ready;
    assign last_step   = (col == LAST_COL) && (scan_y == LAST_ROW);
    assign busy        = (state == SCAN) || (state == DRAIN);
    assign pipe_empty  = !(s1.valid || s2.valid || s3.valid);

    // col counts steps taken within the current row, independent of the
    // serpentine direction, so the row-start DOWN step is simply col == 0.
    always_comb begin
        if ((col == '0) && (scan_y != '0)) begin
            step_dir = DIR_DOWN;
        end else if (scan_y[0]) begin
            step_dir = DIR_LEFT;
        end else begin
            step_dir = DIR_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= IDLE;
            col    <= '0;
            scan_x <= '0;
            scan_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SCAN;
                        col    <= '0;
                        scan_x <= '0;
                        scan_y <= '0;
                    end
                end
                SCAN: begin
                    if (bus.mem_ready) begin
                        if (last_step) begin
                            // Coordinates stay on the final pixel of the frame.
                            state <= DRAIN;
                        end else if (col == LAST_COL) begin
                            // The next step moves down, so x stays on this edge.
                            col    <= '0;
                            scan_y <= scan_y + 1'b1;
                        end else begin
                            col    <= col + 1'b1;
                            scan_x <= scan_y[0] ? (scan_x - 1'b1) : (scan_x + 1'b1);
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage 0 is combinational on the issuing cycle; its incoming good flag
    // is always set.
    always_comb begin
        s0       = EMPTY_ENTRY;
        s0.valid = step;
        s0.dir   = step_dir;
        s0.good  = 1'b1;
    end

    stage_fill_tracker #(.FILL(FILL_GAUSS)) u_fill_gauss (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (frame_start),
        .shift    (s0.valid),
        .good_in  (s0.good),
        .good_out (good0)
    );

    stage_fill_tracker #(.FILL(FILL_GRAD)) u_fill_grad (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (frame_start),
        .shift    (s1.valid),
        .good_in  (s1.good),
        .good_out (good1)
    );

    stage_fill_tracker #(.FILL(FILL_SUPP)) u_fill_supp (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (frame_start),
        .shift    (s2.valid),
        .good_in  (s2.good),
        .good_out (good2)
    );

    stage_fill_tracker #(.FILL(FILL_HYST)) u_fill_hyst (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (frame_start),
        .shift    (s3.valid),
        .good_in  (s3.good),
        .good_out (good3)
    );

    // Each slot carries the good flag produced by the stage before it;
    // bubbles (valid=0) flow through unchanged and never stall the chain.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1 <= EMPTY_ENTRY;
            s2 <= EMPTY_ENTRY;
            s3 <= EMPTY_ENTRY;
        end else begin
            s1 <= '{valid: s0.valid, dir: s0.dir, good: good0};
            s2 <= '{valid: s1.valid, dir: s1.dir, good: good1};
            s3 <= '{valid: s2.valid, dir: s2.dir, good: good2};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            write_enable <= 1'b0;
        end else begin
            write_enable <= s3.valid && good3;
        end
    end

    // Address is presented during the strobe and advances afterwards.
    always_ff @(posedge clk) begin
        if (!n_rst || frame_start) begin
            write_address <= '0;
        end else if (write_enable) begin
            write_address <= write_address + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            error <= 1'b0;
        end else begin
            error <= bus.start && busy;
        end
    end

`ifdef CANNY_STALL_COUNT_EN
    logic [15:0] stall_cycles;

    always_ff @(posedge clk) begin
        if (!n_rst || frame_start) begin
            stall_cycles <= '0;
        end else if ((state == SCAN) && !bus.mem_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cycles;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.gauss_en      = s0.valid;
    assign bus.grad_en       = s1.valid;
    assign bus.supp_en       = s2.valid;
    assign bus.hyst_en       = s3.valid;
    assign bus.gauss_dir     = shown_dir(s0);
    assign bus.grad_dir      = shown_dir(s1);
    assign bus.supp_dir      = shown_dir(s2);
    assign bus.hyst_dir      = shown_dir(s3);
    assign bus.write_enable  = write_enable;
    assign bus.write_address = write_address;
    assign bus.scan_x        = scan_x;
    assign bus.scan_y        = scan_y;
    assign bus.busy          = busy;
    assign bus.frame_done    = (state == DONE);
    assign bus.error         = error;

endmodule

// File: tb/tb_canny_stage_scheduler.sv
// Bench for canny_stage_scheduler on an 8x4 frame with default fill depths.
// A step-indexed reference model predicts every output each cycle; frame-level
// literal expectations (dir sequence, write count/addresses, latency) pin it.
module tb_canny_stage_scheduler;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;
    // 9 + 7 + 5 + 3 - 4: first step index that is primed through stage 3.
    localparam int FIRST_GOOD = 20;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    canny_stage_scheduler_if sif ();

    canny_stage_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (sif)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Serpentine geometry of step i.
    function automatic int dir_of(input int i);
        if (i == 0) return 0;
        if ((i % W) == 0) return 2;
        return (((i / W) % 2) == 1) ? 1 : 0;
    endfunction

    function automatic int x_of(input int i);
        int c;
        c = i % W;
        return (((i / W) % 2) == 1) ? (W - 1 - c) : c;
    endfunction

    function automatic int y_of(input int i);
        return i / W;
    endfunction

    function automatic int code_of(input byte ch);
        if (ch == "R") return 0;
        if (ch == "L") return 1;
        if (ch == "D") return 2;
        return 3;
    endfunction

    // Reference model state.
    bit     chk_on = 1'b0;
    int     hist[4] = '{-1, -1, -1, -1};
    bit     m_active = 1'b0;
    int     m_steps = 0;
    longint m_last = -100;
    int     m_addr = 0;
    int     m_stall = 0;
    bit     m_err = 1'b0;
    longint cyc = 0;

    // Observations of the DUT for frame-level literal checks.
    int     obs_gshift = 0;
    int     obs_writes = 0;
    int     obs_done = 0;
    int     obs_err = 0;
    int     log_gdir[1024];
    longint log_gcyc[1024];
    int     log_waddr[1024];
    longint log_wcyc[1024];

    always @(negedge clk) begin : cmp
        bit scanning;
        bit draining;
        bit done_cyc;
        bit busy_e;
        bit issue;
        int cur;
        cyc++;
        scanning = m_active && (m_steps < N);
        draining = m_active && (m_steps == N) && ((cyc - m_last) <= 4);
        done_cyc = m_active && (m_steps == N) && ((cyc - m_last) == 5);
        busy_e   = scanning || draining;
        issue    = scanning && (sif.mem_ready == 1'b1);
        cur      = (m_steps < N) ? m_steps : (N - 1);
        if (chk_on) begin
            chk("gauss_en", sif.gauss_en, issue);
            chk("gauss_dir", sif.gauss_dir, issue ? dir_of(m_steps) : 3);
            chk("grad_en", sif.grad_en, hist[0] >= 0);
            chk("grad_dir", sif.grad_dir, (hist[0] >= 0) ? dir_of(hist[0]) : 3);
            chk("supp_en", sif.supp_en, hist[1] >= 0);
            chk("supp_dir", sif.supp_dir, (hist[1] >= 0) ? dir_of(hist[1]) : 3);
            chk("hyst_en", sif.hyst_en, hist[2] >= 0);
            chk("hyst_dir", sif.hyst_dir, (hist[2] >= 0) ? dir_of(hist[2]) : 3);
            chk("write_enable", sif.write_enable, hist[3] >= FIRST_GOOD);
            chk("write_address", sif.write_address, m_addr);
            chk("scan_x", sif.scan_x, x_of(cur));
            chk("scan_y", sif.scan_y, y_of(cur));
            chk("busy", sif.busy, busy_e);
            chk("frame_done", sif.frame_done, done_cyc);
            chk("error", sif.error, m_err);
`ifdef CANNY_STALL_COUNT_EN
            chk("stall_cycles", sif.stall_cycles, m_stall);
`else
            chk("stall_cycles", sif.stall_cycles, 0);
`endif
        end
        if (sif.gauss_en === 1'b1 && obs_gshift < 1024) begin
            log_gdir[obs_gshift] = int'(sif.gauss_dir);
            log_gcyc[obs_gshift] = cyc;
            obs_gshift++;
        end
        if (sif.write_enable === 1'b1 && obs_writes < 1024) begin
            log_waddr[obs_writes] = int'(sif.write_address);
            log_wcyc[obs_writes] = cyc;
            obs_writes++;
        end
        if (sif.frame_done === 1'b1) obs_done++;
        if (sif.error === 1'b1) obs_err++;

        if (n_rst !== 1'b1) begin
            m_active = 1'b0;
            m_steps  = 0;
            m_addr   = 0;
            m_stall  = 0;
            m_err    = 1'b0;
            m_last   = -100;
            hist     = '{-1, -1, -1, -1};
        end else begin
            m_err = (sif.start == 1'b1) && busy_e;
            if (hist[3] >= FIRST_GOOD) m_addr++;
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = issue ? m_steps : -1;
            if (scanning && (sif.mem_ready != 1'b1) && (m_stall < 65535)) m_stall++;
            if (issue) begin
                m_steps++;
                if (m_steps == N) m_last = cyc;
            end
            if (done_cyc) begin
                m_active = 1'b0;
            end else if (!m_active && (sif.start == 1'b1)) begin
                m_active = 1'b1;
                m_steps  = 0;
                m_addr   = 0;
                m_stall  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 always ready, 1 alternating, 2 random, 3 five stalls early on.
    task automatic run_frame(input int mode, input int err_step, input int rst_step);
        int d0;
        bit err_sent;
        d0 = obs_done;
        err_sent = 1'b0;
        sif.start = 1'b1;
        sif.mem_ready = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obs_done != d0) break;
            if (rst_step >= 0 && m_steps == rst_step) begin
                n_rst = 1'b0;
                sif.mem_ready = 1'b1;
                tick();
                n_rst = 1'b1;
                tick();
                return;
            end
            case (mode)
                0: sif.mem_ready = 1'b1;
                1: sif.mem_ready = ((i % 2) == 0);
                2: sif.mem_ready = ($urandom_range(0, 3) != 0);
                default: sif.mem_ready = !(i >= 3 && i < 8);
            endcase
            sif.start = (err_step >= 0) && !err_sent && (m_steps == err_step);
            if (sif.start) err_sent = 1'b1;
            tick();
        end
        sif.start = 1'b0;
        chk("frame_done_count", obs_done - d0, 1);
        tick();
        tick();
    endtask

    initial begin : stim
        int gs0;
        int w0;
        int e0;
        string exp_dirs;
        exp_dirs = "RRRRRRRRDLLLLLLLDRRRRRRRDLLLLLLL";
        sif.start = 1'b0;
        sif.mem_ready = 1'b0;
        n_rst = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        chk_on = 1'b1;
        tick();
        chk("rst_gauss_en", sif.gauss_en, 0);
        chk("rst_gauss_dir", sif.gauss_dir, 3);
        chk("rst_hyst_dir", sif.hyst_dir, 3);
        chk("rst_write_address", sif.write_address, 0);
        chk("rst_busy", sif.busy, 0);

        // Frame A: always ready.
        gs0 = obs_gshift; w0 = obs_writes;
        run_frame(0, -1, -1);
        chk("A_shifts", obs_gshift - gs0, 32);
        chk("A_writes", obs_writes - w0, 12);
        chk("A_first_addr", log_waddr[w0], 0);
        chk("A_last_addr", log_waddr[w0 + 11], 11);
        chk("A_write_lag", 32'(log_wcyc[w0] - log_gcyc[gs0 + 20]), 4);
        for (int i = 0; i < 32; i++) chk("A_dir", log_gdir[gs0 + i], code_of(exp_dirs[i]));
        chk("A_busy_after", sif.busy, 0);

        // Frame B: mem_ready alternating.
        gs0 = obs_gshift; w0 = obs_writes;
        run_frame(1, -1, -1);
        chk("B_shifts", obs_gshift - gs0, 32);
        chk("B_writes", obs_writes - w0, 12);
        chk("B_last_addr", log_waddr[w0 + 11], 11);

        // Frame C: random ready, illegal start at step 10.
        gs0 = obs_gshift; w0 = obs_writes; e0 = obs_err;
        run_frame(2, 10, -1);
        chk("C_error_pulses", obs_err - e0, 1);
        chk("C_shifts", obs_gshift - gs0, 32);
        chk("C_writes", obs_writes - w0, 12);
        for (int i = 0; i < 32; i++) chk("C_dir", log_gdir[gs0 + i], code_of(exp_dirs[i]));

        // Frame D: reset at step 10, then a fresh frame.
        w0 = obs_writes;
        run_frame(2, -1, 10);
        chk("D_writes", obs_writes - w0, 0);
        chk("D_busy_after_rst", sif.busy, 0);
        chk("D_gauss_dir_after_rst", sif.gauss_dir, 3);
        w0 = obs_writes;
        run_frame(2, -1, -1);
        chk("E_writes", obs_writes - w0, 12);
        chk("E_first_addr", log_waddr[w0], 0);
        chk("E_last_addr", log_waddr[w0 + 11], 11);

        // Frame F: exactly five stall cycles during SCAN.
        w0 = obs_writes;
        run_frame(3, -1, -1);
        chk("F_writes", obs_writes - w0, 12);
`ifdef CANNY_STALL_COUNT_EN
        chk("F_stall_cycles", sif.stall_cycles, 5);
`else
        chk("F_stall_cycles", sif.stall_cycles, 0);
`endif

        // A few more random frames.
        for (int f = 0; f < 3; f++) begin
            w0 = obs_writes;
            run_frame(2, -1, -1);
            chk("R_writes", obs_writes - w0, 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
